// File: rtl/ifetch_unit_if.sv
// IM read port and decode-side instruction stream of the fetch stage.
// The master modport is the fetch unit; slave is the memory/decode environment.
interface ifetch_unit_if #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
);
  logic [MemSize-1:0]  PC;
  logic                IM_read;
  logic                IM_write;
  logic                IM_enable;
  logic [DataSize-1:0] instruction;
  logic                stall;
  logic                branch_valid;
  logic [MemSize-1:0]  branch_target;
  logic                inst_valid;
  logic [DataSize-1:0] inst_out;
  logic [MemSize-1:0]  inst_pc;

  modport master (
    output PC, IM_read, IM_write, IM_enable, inst_valid, inst_out, inst_pc,
    input  instruction, stall, branch_valid, branch_target
  );

  modport slave (
    input  PC, IM_read, IM_write, IM_enable, inst_valid, inst_out, inst_pc,
    output instruction, stall, branch_valid, branch_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues IM reads and hides the one-cycle IM
// latency behind a 2-entry prefetch FIFO whose head feeds decode directly.
module ifetch_unit #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10
) (
  input logic           clk,
  input logic           reset,
  ifetch_unit_if.master bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [MemSize-1:0]  pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [MemSize-1:0]  tag_q, tag_d;
  logic [1:0]          count_q, count_d;
  logic [DataSize-1:0] head_data_q, head_data_d;
  logic [MemSize-1:0]  head_pc_q, head_pc_d;
  logic [DataSize-1:0] tail_data_q, tail_data_d;
  logic [MemSize-1:0]  tail_pc_q, tail_pc_d;

  logic run, pop, push, room, issue;

  assign run   = (state_q == S_RUN);
  assign pop   = (count_q != 2'd0) && !bus.stall;
  // A response arriving in a redirect cycle belongs to the old stream.
  assign push  = inflight_q && !bus.branch_valid;
  assign room  = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
  assign issue = run && !reset && !bus.branch_valid && (room || pop);

  assign bus.PC         = pc_q;
  assign bus.IM_read    = issue;
  assign bus.IM_write   = 1'b0;
  assign bus.IM_enable  = run;
  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst_out   = head_data_q;
  assign bus.inst_pc    = head_pc_q;

  always_comb begin
    state_d     = S_RUN;
    pc_d        = pc_q;
    inflight_d  = issue;
    tag_d       = issue ? pc_q : tag_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    tail_data_d = tail_data_q;
    tail_pc_d   = tail_pc_q;

    if (bus.branch_valid)
      pc_d = bus.branch_target;
    else if (issue)
      pc_d = pc_q + MemSize'(1);

    if (bus.branch_valid) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_d = bus.instruction;
            head_pc_d   = tag_q;
          end else begin
            tail_data_d = bus.instruction;
            tail_pc_d   = tag_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_data_d = tail_data_q;
          head_pc_d   = tail_pc_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the occupancy; new entry lands behind any survivor.
          if (count_q == 2'd1) begin
            head_data_d = bus.instruction;
            head_pc_d   = tag_q;
          end else begin
            head_data_d = tail_data_q;
            head_pc_d   = tail_pc_q;
            tail_data_d = bus.instruction;
            tail_pc_d   = tag_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      assert (!(push && !pop && count_q == 2'd2));
    end
  end

  always_ff @(posedge clk) begin
    tag_q       <= tag_d;
    tail_data_q <= tail_data_d;
    tail_pc_q   <= tail_pc_d;
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_ifetch_unit;
  localparam int DW = 32;
  localparam int MW = 10;

  logic clk = 1'b0;
  logic reset;

  ifetch_unit_if #(.DataSize(DW), .MemSize(MW)) bus();
  ifetch_unit #(.DataSize(DW), .MemSize(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory: one-cycle registered read, mem[k] = 32'h1000_0000 + k.
  logic [31:0] im_data;
  always @(posedge clk) begin
    if (bus.IM_read && bus.IM_enable) im_data <= 32'h1000_0000 + 32'(bus.PC);
    else                              im_data <= 32'hDEAD_BEEF;
  end
  assign bus.instruction = im_data;

  // Reference model: buffered instructions and outstanding fetches as queues.
  typedef struct packed { logic [31:0] d; logic [9:0] a; } ent_t;
  ent_t m_fifo[$];
  int   m_fly[$];
  bit   m_run = 1'b0;
  int   m_pc  = 0;

  function automatic bit exp_read();
    return m_run && !reset && !bus.branch_valid &&
           ((m_fifo.size() + m_fly.size()) < 2 || (m_fifo.size() > 0 && !bus.stall));
  endfunction

  always @(posedge clk) begin
    bit rd;
    int a;
    rd = exp_read();
    if (reset) begin
      m_fifo.delete(); m_fly.delete(); m_run = 1'b0; m_pc = 0;
    end else if (bus.branch_valid) begin
      m_fifo.delete(); m_fly.delete(); m_pc = int'(bus.branch_target); m_run = 1'b1;
    end else begin
      if (m_fifo.size() > 0 && !bus.stall) void'(m_fifo.pop_front());
      if (m_fly.size() > 0) begin
        a = m_fly.pop_front();
        m_fifo.push_back({32'h1000_0000 + 32'(a), 10'(a)});
      end
      if (rd) begin
        m_fly.push_back(m_pc);
        m_pc = (m_pc + 1) % 1024;
      end
      m_run = 1'b1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_IM_read",    32'(bus.IM_read),    32'(exp_read()));
      check("m_IM_enable",  32'(bus.IM_enable),  32'(m_run));
      check("m_IM_write",   32'(bus.IM_write),   32'd0);
      check("m_PC",         32'(bus.PC),         32'(m_pc));
      check("m_inst_valid", 32'(bus.inst_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        check("m_inst_pc",  32'(bus.inst_pc), 32'(m_fifo[0].a));
        check("m_inst_out", bus.inst_out,     m_fifo[0].d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input string name, input int pc);
    check({name, "_valid"}, 32'(bus.inst_valid), 32'd1);
    check({name, "_pc"},    32'(bus.inst_pc),    32'(pc));
    check({name, "_out"},   bus.inst_out,        32'h1000_0000 + 32'(pc));
  endtask

  task automatic wait_pc(input int target, input int budget);
    int n = 0;
    while (!(bus.inst_valid && bus.inst_pc == 10'(target)) && n < budget) begin
      tick();
      n++;
    end
    check("wait_pc", 32'(bus.inst_pc), 32'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int wrap_seq[4];
    wrap_seq = '{1022, 1023, 0, 1};
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_valid",  32'(bus.inst_valid), 32'd0);
    check("rst_out",    bus.inst_out,        32'd0);
    check("rst_pc",     32'(bus.inst_pc),    32'd0);
    check("rst_PC",     32'(bus.PC),         32'd0);
    check("rst_read",   32'(bus.IM_read),    32'd0);
    check("rst_enable", 32'(bus.IM_enable),  32'd0);
    check("rst_write",  32'(bus.IM_write),   32'd0);
    cmp_en = 1'b1;

    // Reset release: read rises in 2nd cycle, first valid two cycles later
    tick(); reset = 1'b0; @(negedge clk);
    check("c1_read", 32'(bus.IM_read), 32'd0);
    tick(); @(negedge clk);
    check("c2_read", 32'(bus.IM_read), 32'd1);
    check("c2_PC",   32'(bus.PC),      32'd0);
    tick(); @(negedge clk);
    check("c3_valid", 32'(bus.inst_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      expect_inst("stream", k);
    end

    // Stall 5 cycles at pc 3
    tick(); bus.stall = 1'b1; @(negedge clk);
    expect_inst("stall0", 3);
    check("stall0_read", 32'(bus.IM_read), 32'd0);
    for (int k = 1; k < 5; k++) begin
      tick(); @(negedge clk);
      expect_inst("stall", 3);
      check("stall_read", 32'(bus.IM_read), 32'd0);
      check("stall_PC",   32'(bus.PC),      32'd5);
    end
    tick(); bus.stall = 1'b0; @(negedge clk);
    expect_inst("rel", 3);
    check("rel_read", 32'(bus.IM_read), 32'd1);
    tick(); @(negedge clk); expect_inst("rel", 4);
    tick(); @(negedge clk); expect_inst("rel", 5);

    // Branch to 100 with FIFO holding 6,7
    tick(); bus.stall = 1'b1; @(negedge clk);
    expect_inst("pre_br", 6);
    tick(); bus.stall = 1'b0; bus.branch_valid = 1'b1; bus.branch_target = 10'd100; @(negedge clk);
    check("br_read", 32'(bus.IM_read), 32'd0);
    tick(); bus.branch_valid = 1'b0; @(negedge clk);
    check("br1_valid", 32'(bus.inst_valid), 32'd0);
    check("br1_read",  32'(bus.IM_read),    32'd1);
    check("br1_PC",    32'(bus.PC),         32'd100);
    tick(); @(negedge clk);
    check("br2_valid", 32'(bus.inst_valid), 32'd0);
    tick(); @(negedge clk); expect_inst("br3", 100);
    tick(); @(negedge clk); expect_inst("br4", 101);

    // Wrap-around
    tick(); bus.branch_valid = 1'b1; bus.branch_target = 10'd1022; @(negedge clk);
    tick(); bus.branch_valid = 1'b0; @(negedge clk);
    tick(); @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      expect_inst("wrap", wrap_seq[k]);
    end

    // Branch together with stall
    tick(); bus.stall = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 10'd40; @(negedge clk);
    check("bs_read", 32'(bus.IM_read), 32'd0);
    tick(); bus.branch_valid = 1'b0; @(negedge clk);
    check("bs1_valid", 32'(bus.inst_valid), 32'd0);
    check("bs1_PC",    32'(bus.PC),         32'd40);
    tick(); bus.stall = 1'b0; @(negedge clk);
    check("bs2_valid", 32'(bus.inst_valid), 32'd0);
    tick(); @(negedge clk); expect_inst("bs3", 40);
    tick(); @(negedge clk); expect_inst("bs4", 41);

    // Reset mid-stream at pc 20
    tick(); bus.branch_valid = 1'b1; bus.branch_target = 10'd17; @(negedge clk);
    tick(); bus.branch_valid = 1'b0;
    wait_pc(20, 10);
    reset = 1'b1; @(negedge clk);
    expect_inst("pre_rst", 20);
    tick(); reset = 1'b0; @(negedge clk);
    check("mr_valid",  32'(bus.inst_valid), 32'd0);
    check("mr_pc",     32'(bus.inst_pc),    32'd0);
    check("mr_out",    bus.inst_out,        32'd0);
    check("mr_PC",     32'(bus.PC),         32'd0);
    check("mr_read",   32'(bus.IM_read),    32'd0);
    check("mr_enable", 32'(bus.IM_enable),  32'd0);
    tick(); @(negedge clk);
    check("mr2_read",  32'(bus.IM_read),    32'd1);
    check("mr2_valid", 32'(bus.inst_valid), 32'd0);
    tick(); @(negedge clk);
    check("mr3_valid", 32'(bus.inst_valid), 32'd0);
    tick(); @(negedge clk); expect_inst("mr4", 0);

    // Irregular stall pattern with one redirect, checked by the model
    for (int i = 0; i < 60; i++) begin
      tick();
      bus.stall = ($urandom % 3) == 0;
      bus.branch_valid = (i == 30);
      bus.branch_target = 10'($urandom);
      @(negedge clk);
    end
    tick(); bus.stall = 1'b0; bus.branch_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
